pp_udiv_share_ctrl: RTL

- Round-robin arbiter and sequencer that shares one 64/16 unsigned sequential divider among NUM_REQ requesters in the pp_pipeline_accel datapath.
- Accepts divide requests over valid/ready, issues one division at a time, and waits for the divider's done pulse.
- Returns the quotient to the owning requester over valid/ready.
- Handles divide-by-zero locally, without using the divider, and guards against a missing done with a watchdog.

---
 rtl/pp_udiv_share_pkg.sv | 20 ++
 rtl/pp_udiv_rr_arb.sv | 37 +++
 rtl/pp_udiv_share_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pp_udiv_share_pkg.sv
// rtl/pp_udiv_share_pkg.sv - shared types and defaults for the divider sharing controller
package pp_udiv_share_pkg;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_DIVIDEND_WIDTH = 64;
   localparam int DEF_DIVISOR_WIDTH  = 16;
   localparam int DEF_TIMEOUT        = 80;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_DBZ = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;

endpackage

// File: rtl/pp_udiv_rr_arb.sv
// rtl/pp_udiv_rr_arb.sv - combinational round-robin arbiter; the pointer register lives in the parent
module pp_udiv_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   idx,
   output logic               found
);

   always_comb begin
      int c;
      logic [PTR_W-1:0] ci;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      ci    = '0;
      // scan starts at the pointer and wraps, so the first hit is the fair winner
      for (int k = 0; k < NUM_REQ; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_REQ) begin
            c = c - NUM_REQ;
         end
         ci = PTR_W'(c);
         if (en && !found && req[ci]) begin
            found     = 1'b1;
            grant[ci] = 1'b1;
            idx       = ci;
         end
      end
   end

endmodule

// File: rtl/pp_udiv_share_ctrl.sv
// rtl/pp_udiv_share_ctrl.sv - shares one sequential 64/16 divider among NUM_REQ requesters
module pp_udiv_share_ctrl
   import pp_udiv_share_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
   parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
   parameter int TIMEOUT        = DEF_TIMEOUT
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
   input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   input  logic [NUM_REQ-1:0]                  rsp_ready,
   output logic [DIVIDEND_WIDTH-1:0]           rsp_quot,
   output logic [1:0]                          rsp_status,
   output logic                                div_ce,
   output logic                                div_start,
   output logic [DIVIDEND_WIDTH-1:0]           div_din0,
   output logic [DIVISOR_WIDTH-1:0]            div_din1,
   input  logic                                div_done,
   input  logic [DIVIDEND_WIDTH-1:0]           div_dout,
   output logic                                busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t                    state, state_nxt;
   logic [PTR_W-1:0]          ptr, owner, gidx, ptr_nxt;
   logic [CNT_W-1:0]          cnt;
   logic [DIVIDEND_WIDTH-1:0] din0_q, quot_q, sel_dividend;
   logic [DIVISOR_WIDTH-1:0]  din1_q, sel_divisor;
   logic [1:0]                status_q;
   logic [NUM_REQ-1:0]        grant;
   logic                      gfound, timeout_hit, divisor_zero;

   pp_udiv_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .en    (state == IDLE && !reset),
      .grant (grant),
      .idx   (gidx),
      .found (gfound)
   );

   always_comb begin
      sel_dividend = '0;
      sel_divisor  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx == PTR_W'(i)) begin
            sel_dividend = req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
            sel_divisor  = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
         end
      end
   end

   assign divisor_zero = (sel_divisor == '0);
   assign ptr_nxt      = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
   // the cycle in which the counter would reach TIMEOUT is the last WAIT cycle
   assign timeout_hit  = (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      div_start = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            req_ready = grant;
            if (gfound) begin
               state_nxt = divisor_zero ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            div_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (div_done || timeout_hit) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid[owner] = 1'b1;
            if (rsp_ready[owner]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         cnt      <= '0;
         din0_q   <= '0;
         din1_q   <= '0;
         quot_q   <= '0;
         status_q <= ST_OK;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (gfound) begin
                  owner  <= gidx;
                  ptr    <= ptr_nxt;
                  din0_q <= sel_dividend;
                  din1_q <= sel_divisor;
                  if (divisor_zero) begin
                     quot_q   <= '1;
                     status_q <= ST_DBZ;
                  end
               end
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               cnt <= cnt + CNT_W'(1);
               // a done coinciding with the timeout cycle still wins
               if (div_done) begin
                  quot_q   <= div_dout;
                  status_q <= ST_OK;
               end else if (timeout_hit) begin
                  quot_q   <= '0;
                  status_q <= ST_TMO;
               end
            end
            default: ;
         endcase
      end
   end

   assign div_ce     = ~reset;
   assign div_din0   = din0_q;
   assign div_din1   = din1_q;
   assign rsp_quot   = quot_q;
   assign rsp_status = status_q;

endmodule
